// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD-line engine: receives 48-bit host commands, validates framing and
// CRC7, and serializes the short or long response supplied by card logic.
module neosd_card_cmd #(
    parameter int NCR = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sd_clk_i,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    output logic         cmd_valid_o,
    output logic         cmd_err_o,
    output logic [5:0]   cmd_idx_o,
    output logic [31:0]  cmd_arg_o,
    input  logic         resp_valid_i,
    output logic         resp_ready_o,
    input  logic [1:0]   resp_mode_i,
    input  logic [5:0]   resp_idx_i,
    input  logic [31:0]  resp_arg_i,
    input  logic [119:0] resp_long_i,
    output logic         busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;

    localparam logic [6:0] NCR_L = 7'(NCR);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_short(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    function automatic logic [6:0] crc7_long(input logic [119:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 119; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    logic [1:0]   sclk_sync_q, sclk_sync_d;
    logic [1:0]   scmd_sync_q, scmd_sync_d;
    logic         sclk_prev_q, sclk_prev_d;
    logic [2:0]   state_q, state_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [6:0]   crc_q, crc_d;
    logic [47:0]  rx_sr_q, rx_sr_d;
    logic [6:0]   ncr_cnt_q, ncr_cnt_d;
    logic         resp_held_q, resp_held_d;
    logic [1:0]   resp_mode_q, resp_mode_d;
    logic [5:0]   resp_idx_q, resp_idx_d;
    logic [31:0]  resp_arg_q, resp_arg_d;
    logic [119:0] resp_long_q, resp_long_d;
    logic [135:0] tx_sr_q, tx_sr_d;
    logic [7:0]   tx_len_q, tx_len_d;
    logic         cmd_o_q, cmd_o_d;
    logic         cmd_oe_q, cmd_oe_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic         cmd_err_q, cmd_err_d;
    logic [5:0]   cmd_idx_q, cmd_idx_d;
    logic [31:0]  cmd_arg_q, cmd_arg_d;

    logic         rise, fall, cmd_bit, accept, frame_err;
    logic [6:0]   crc_s, crc_l;
    logic [135:0] tx_frame;

    assign rise    = sclk_sync_q[1] & ~sclk_prev_q;
    assign fall    = ~sclk_sync_q[1] & sclk_prev_q;
    assign cmd_bit = scmd_sync_q[1];

    assign resp_ready_o = (state_q == S_WAIT) && !resp_held_q;
    assign accept       = resp_ready_o && resp_valid_i;
    assign busy_o       = (state_q != S_IDLE);
    assign sd_cmd_o     = cmd_o_q;
    assign sd_cmd_oe    = cmd_oe_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_err_o    = cmd_err_q;
    assign cmd_idx_o    = cmd_idx_q;
    assign cmd_arg_o    = cmd_arg_q;

    // Response frame is left-aligned so the shifter always sends bit 135 first.
    always_comb begin
        crc_s = crc7_short({2'b00, resp_idx_q, resp_arg_q});
        crc_l = crc7_long(resp_long_q);
        if (resp_mode_q == 2'b11)
            tx_frame = {2'b00, 6'h3F, resp_long_q, crc_l, 1'b1};
        else
            tx_frame = {2'b00, resp_idx_q, resp_arg_q,
                        (resp_mode_q == 2'b10) ? 7'h7F : crc_s, 1'b1, 88'd0};
    end

    assign frame_err = (crc_q != rx_sr_q[7:1]) || !rx_sr_q[46] || !rx_sr_q[0];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[0], sd_clk_i};
        scmd_sync_d = {scmd_sync_q[0], sd_cmd_i};
        sclk_prev_d = sclk_sync_q[1];
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        rx_sr_d     = rx_sr_q;
        ncr_cnt_d   = ncr_cnt_q;
        resp_held_d = resp_held_q;
        resp_mode_d = resp_mode_q;
        resp_idx_d  = resp_idx_q;
        resp_arg_d  = resp_arg_q;
        resp_long_d = resp_long_q;
        tx_sr_d     = tx_sr_q;
        tx_len_d    = tx_len_q;
        cmd_o_d     = cmd_o_q;
        cmd_oe_d    = cmd_oe_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = cmd_err_q;
        cmd_idx_d   = cmd_idx_q;
        cmd_arg_d   = cmd_arg_q;

        case (state_q)
            S_IDLE: begin
                if (rise && !cmd_bit) begin
                    state_d   = S_RECV;
                    bit_cnt_d = 8'd1;
                    rx_sr_d   = 48'd0;
                    crc_d     = crc7_step(7'd0, 1'b0);
                end
            end
            S_RECV: begin
                if (rise) begin
                    rx_sr_d   = {rx_sr_q[46:0], cmd_bit};
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    // Only the first 40 bits (start through argument) feed the CRC.
                    if (bit_cnt_q < 8'd40) crc_d = crc7_step(crc_q, cmd_bit);
                    if (bit_cnt_q == 8'd47) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cmd_valid_d = 1'b1;
                cmd_idx_d   = rx_sr_q[45:40];
                cmd_arg_d   = rx_sr_q[39:8];
                cmd_err_d   = frame_err;
                ncr_cnt_d   = 7'd0;
                resp_held_d = 1'b0;
                state_d     = frame_err ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (rise && ncr_cnt_q != NCR_L) ncr_cnt_d = ncr_cnt_q + 7'd1;
                if (accept) begin
                    resp_mode_d = resp_mode_i;
                    resp_idx_d  = resp_idx_i;
                    resp_arg_d  = resp_arg_i;
                    resp_long_d = resp_long_i;
                    if (resp_mode_i == 2'b00) state_d = S_IDLE;
                    else resp_held_d = 1'b1;
                end else if (fall && resp_held_q && ncr_cnt_q == NCR_L) begin
                    state_d   = S_SEND;
                    cmd_o_d   = tx_frame[135];
                    cmd_oe_d  = 1'b1;
                    tx_sr_d   = {tx_frame[134:0], 1'b0};
                    bit_cnt_d = 8'd1;
                    tx_len_d  = (resp_mode_q == 2'b11) ? 8'd136 : 8'd48;
                end
            end
            S_SEND: begin
                if (fall) begin
                    if (bit_cnt_q == tx_len_q) begin
                        cmd_oe_d    = 1'b0;
                        cmd_o_d     = 1'b1;
                        resp_held_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cmd_o_d   = tx_sr_q[135];
                        tx_sr_d   = {tx_sr_q[134:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= 2'b00;
            scmd_sync_q <= 2'b11;
            sclk_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 8'd0;
            crc_q       <= 7'd0;
            rx_sr_q     <= 48'd0;
            ncr_cnt_q   <= 7'd0;
            resp_held_q <= 1'b0;
            resp_mode_q <= 2'b00;
            resp_idx_q  <= 6'd0;
            resp_arg_q  <= 32'd0;
            resp_long_q <= 120'd0;
            tx_sr_q     <= 136'd0;
            tx_len_q    <= 8'd0;
            cmd_o_q     <= 1'b1;
            cmd_oe_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_idx_q   <= 6'd0;
            cmd_arg_q   <= 32'd0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            scmd_sync_q <= scmd_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            rx_sr_q     <= rx_sr_d;
            ncr_cnt_q   <= ncr_cnt_d;
            resp_held_q <= resp_held_d;
            resp_mode_q <= resp_mode_d;
            resp_idx_q  <= resp_idx_d;
            resp_arg_q  <= resp_arg_d;
            resp_long_q <= resp_long_d;
            tx_sr_q     <= tx_sr_d;
            tx_len_q    <= tx_len_d;
            cmd_o_q     <= cmd_o_d;
            cmd_oe_q    <= cmd_oe_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_arg_q   <= cmd_arg_d;
        end
    end

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Scoreboard bench for neosd_card_cmd: the host side drives command frames on CMD,
// monitors pop expected command reports and response frames as the DUT produces them.
module tb_neosd_card_cmd;

    localparam int NCR = 2;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        err;
    } cmd_exp_t;

    typedef struct {
        logic [135:0] bits;
        int           len;
        int           start_rise;
        bit           trunc;
    } resp_exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sd_clk = 1'b0;
    logic         host_drv = 1'b1;
    logic         cmd_line;
    logic         sd_cmd_o, sd_cmd_oe;
    logic         cmd_valid_o, cmd_err_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         resp_valid = 1'b0;
    logic         resp_ready_o;
    logic [1:0]   resp_mode = 2'b00;
    logic [5:0]   resp_idx = 6'd0;
    logic [31:0]  resp_arg = 32'd0;
    logic [119:0] resp_long = 120'd0;
    logic         busy_o;

    cmd_exp_t  cmd_q[$];
    resp_exp_t resp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int rise_n = 0;
    int last_end_rise = 0;
    bit ready_seen = 0;
    bit oe_seen = 0;
    bit cap = 0;
    bit post = 0;

    assign cmd_line = sd_cmd_oe ? sd_cmd_o : host_drv;

    neosd_card_cmd #(.NCR(NCR)) dut (
        .clk_i(clk), .rst_i(rst), .sd_clk_i(sd_clk), .sd_cmd_i(cmd_line),
        .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe),
        .cmd_valid_o(cmd_valid_o), .cmd_err_o(cmd_err_o),
        .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o),
        .resp_valid_i(resp_valid), .resp_ready_o(resp_ready_o),
        .resp_mode_i(resp_mode), .resp_idx_i(resp_idx), .resp_arg_i(resp_arg),
        .resp_long_i(resp_long), .busy_o(busy_o)
    );

    initial forever #5 clk = ~clk;
    initial forever #40 sd_clk = ~sd_clk;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_ref(input logic [119:0] d);
        logic [6:0] c;
        logic fb;
        c = 7'd0;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c = c << 1;
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Command-report monitor plus sticky flags for "never asserted" checks.
    initial forever begin
        cmd_exp_t e;
        @(negedge clk);
        if (resp_ready_o === 1'b1) ready_seen = 1;
        if (sd_cmd_oe === 1'b1) oe_seen = 1;
        if (cmd_valid_o === 1'b1) begin
            if (cmd_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL cmd_unexpected: got idx %h arg %h, none expected", cmd_idx_o, cmd_arg_o);
            end else begin
                e = cmd_q.pop_front();
                check("cmd_idx", 136'(cmd_idx_o), 136'(e.idx));
                check("cmd_arg", 136'(cmd_arg_o), 136'(e.arg));
                check("cmd_err", 136'(cmd_err_o), 136'(e.err));
            end
        end
    end

    // Host-side line monitor: samples the CMD line on every SD clock rise.
    initial forever begin
        resp_exp_t cur;
        logic [135:0] got;
        int cnt;
        @(posedge sd_clk);
        rise_n++;
        if (post) begin
            check("oe_release", 136'(sd_cmd_oe), 136'(0));
            post = 0;
        end else if (cap) begin
            if (sd_cmd_oe !== 1'b1) begin
                cap = 0;
                if (cur.trunc) check("trunc_short", 136'(cnt < cur.len), 136'(1));
                else begin
                    n_vec++; n_bad++;
                    $display("FAIL resp_truncated: got %0d bits expected %0d", cnt, cur.len);
                end
            end else begin
                got = {got[134:0], sd_cmd_o};
                cnt++;
                if (cnt == cur.len) begin
                    cap = 0;
                    post = 1;
                    check("resp_frame", got << (136 - cur.len), cur.bits);
                end
            end
        end else if (sd_cmd_oe === 1'b1 && sd_cmd_o === 1'b0) begin
            if (resp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL resp_unexpected: got start bit at rise %0d expected none", rise_n);
            end else begin
                cur = resp_q.pop_front();
                cap = 1;
                cnt = 1;
                got = 136'd0;
                check("resp_start_rise", 136'(rise_n), 136'(cur.start_rise));
            end
        end
    end

    task automatic send_cmd(input logic [47:0] f, input logic [5:0] idx,
                            input logic [31:0] arg, input logic err);
        cmd_exp_t e;
        e.idx = idx; e.arg = arg; e.err = err;
        cmd_q.push_back(e);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            host_drv = f[i];
            if (i == 0) last_end_rise = rise_n + 1;
        end
        @(negedge sd_clk);
        host_drv = 1'b1;
    endtask

    task automatic respond(input logic [1:0] mode, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [119:0] lng, input int delay,
                           input logic [135:0] exp_bits, input int exp_len, input bit trunc);
        resp_exp_t r;
        int t = 0;
        while (resp_ready_o !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (resp_ready_o !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL ready_timeout: got resp_ready_o %b expected 1", resp_ready_o);
            return;
        end
        if (delay > 0) begin
            repeat (delay) @(posedge sd_clk);
            #1;
        end
        if (mode != 2'b00) begin
            r.bits = exp_bits; r.len = exp_len; r.trunc = trunc;
            r.start_rise = (delay > 0) ? rise_n + 1 : last_end_rise + NCR + 1;
            resp_q.push_back(r);
        end
        resp_mode = mode; resp_idx = idx; resp_arg = arg; resp_long = lng;
        resp_valid = 1'b1;
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((resp_q.size() != 0 || cmd_q.size() != 0 || cap || post) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 136'(resp_q.size() + cmd_q.size() + int'(cap) + int'(post)), 136'(0));
        repeat (3) @(posedge sd_clk);
        @(negedge clk);
    endtask

    task automatic bad_frame(input logic [47:0] f, input logic [5:0] idx, input logic [31:0] arg);
        ready_seen = 0;
        oe_seen = 0;
        send_cmd(f, idx, arg, 1'b1);
        repeat (10) @(posedge sd_clk);
        @(negedge clk);
        check("err_no_ready", 136'(ready_seen), 136'(0));
        check("err_no_drive", 136'(oe_seen), 136'(0));
        check("err_idle", 136'(busy_o), 136'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected $finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int t;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_o", 136'(sd_cmd_o), 136'(1));
        check("rst_cmd_oe", 136'(sd_cmd_oe), 136'(0));
        check("rst_valid", 136'(cmd_valid_o), 136'(0));
        check("rst_err", 136'(cmd_err_o), 136'(0));
        check("rst_ready", 136'(resp_ready_o), 136'(0));
        check("rst_busy", 136'(busy_o), 136'(0));
        check("rst_idx", 136'(cmd_idx_o), 136'(0));
        check("rst_arg", 136'(cmd_arg_o), 136'(0));
        rst = 1'b0;
        repeat (4) @(posedge sd_clk);

        // CMD0 with no response
        oe_seen = 0;
        send_cmd(48'h400000000095, 6'd0, 32'd0, 1'b0);
        respond(2'b00, 6'd0, 32'd0, 120'd0, 0, 136'd0, 0, 0);
        repeat (20) @(negedge clk);
        check("mode00_idle", 136'(busy_o), 136'(0));
        check("mode00_no_drive", 136'(oe_seen), 136'(0));
        drain();

        // CMD8 with R7-style short response
        send_cmd(48'h48000001AA87, 6'd8, 32'h000001AA, 1'b0);
        respond(2'b01, 6'd8, 32'h000001AA, 120'd0, 0, {48'h08000001AA13, 88'd0}, 48, 0);
        drain();

        // Malformed frames: end bit 0, end bit 0 via CRC byte 86, transmission bit 0, bad CRC
        bad_frame(48'h48000001AA86, 6'd8, 32'h000001AA);
        bad_frame(48'h400000000094, 6'd0, 32'd0);
        bad_frame(48'h000000000095, 6'd0, 32'd0);
        bad_frame(48'h400000000097, 6'd0, 32'd0);
        drain();

        // R3-style response: fixed 7F CRC field
        send_cmd(48'h400000000095, 6'd0, 32'd0, 1'b0);
        respond(2'b10, 6'h3F, 32'h80FF8000, 120'd0, 0, {48'h3F80FF8000FF, 88'd0}, 48, 0);
        drain();

        // R2 long response, all-ones payload
        send_cmd(48'h48000001AA87, 6'd8, 32'h000001AA, 1'b0);
        respond(2'b11, 6'd0, 32'd0, {120{1'b1}}, 0,
                {8'h3F, {120{1'b1}}, crc7_ref({120{1'b1}}), 1'b1}, 136, 0);
        drain();

        // Card logic delays acceptance by 10 SD periods
        send_cmd(48'h48000001AA87, 6'd8, 32'h000001AA, 1'b0);
        respond(2'b01, 6'd8, 32'h000001AA, 120'd0, 10, {48'h08000001AA13, 88'd0}, 48, 0);
        drain();

        // Reset in the middle of a long response, then a fresh CMD0
        send_cmd(48'h48000001AA87, 6'd8, 32'h000001AA, 1'b0);
        respond(2'b11, 6'd0, 32'd0, 120'h0123456789ABCDEF0123456789ABCD, 0, 136'd0, 136, 1);
        t = 0;
        while (sd_cmd_oe !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("send_started", 136'(sd_cmd_oe), 136'(1));
        repeat (20) @(posedge sd_clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_oe", 136'(sd_cmd_oe), 136'(0));
        check("rst_mid_cmd_o", 136'(sd_cmd_o), 136'(1));
        check("rst_mid_busy", 136'(busy_o), 136'(0));
        rst = 1'b0;
        repeat (3) @(posedge sd_clk);
        send_cmd(48'h400000000095, 6'd0, 32'd0, 1'b0);
        respond(2'b00, 6'd0, 32'd0, 120'd0, 0, 136'd0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/neosd_card_cmd.md
Name: neosd_card_cmd

Overview:
- Card-side CMD-line engine: the responder at the far end of the host CMD FSM.
- Receives 48-bit host command frames, checks the framing bits and CRC7, and hands the index and argument to card logic.
- Serializes the short (48-bit) or long (136-bit) response that card logic supplies.
- Used in the SD card model for closed-loop host verification and in FPGA card-emulation builds.

Parameters:
- NCR, 2: SD clock periods between the command end bit and the response start bit (legal range 2..64).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active high
- sd_clk_i  in  1  SD clock from host; asynchronous, sampled on clk_i
- sd_cmd_i  in  1  CMD line input
- sd_cmd_o  out  1  CMD line drive value
- sd_cmd_oe  out  1  CMD output enable
- cmd_valid_o  out  1  one-cycle pulse: command frame received
- cmd_err_o  out  1  qualifies cmd_valid_o: CRC, transmission-bit or end-bit error
- cmd_idx_o  out  6  command index, held until the next frame
- cmd_arg_o  out  32  command argument, held until the next frame
- resp_valid_i  in  1  response offered by card logic
- resp_ready_o  out  1  response accepted when high together with resp_valid_i
- resp_mode_i  in  2  00 none, 01 short with CRC7, 10 short with CRC field 7'h7F (R3), 11 long (R2)
- resp_idx_i  in  6  short-response index field
- resp_arg_i  in  32  short-response payload
- resp_long_i  in  120  R2 payload = CID/CSD[127:8]
- busy_o  out  1  high in every state except IDLE

Behaviour:
- sd_clk_i and sd_cmd_i each pass through 2 flip-flops on clk_i.
- rise is asserted when synced clock = 1 and previous = 0; fall is the converse.
- Reception samples CMD on rise. Transmission changes sd_cmd_o on fall.
- Reset values: sd_cmd_o=1, sd_cmd_oe=0, cmd_valid_o=0, cmd_err_o=0, resp_ready_o=0, busy_o=0, cmd_idx_o=0, cmd_arg_o=0, state IDLE.
- CRC7: polynomial x^7+x^3+1, initial value 0, MSB-first. It covers the start bit through the last payload bit.
- States:
  - IDLE: a sampled 0 on rise → RECV; bit counter=1; CRC updated with the 0.
  - RECV: shift 47 more bits, one per rise; after the 48th bit → CHECK.
    - bit 46 (transmission) must be 1
    - bits 45:40 = idx, bits 39:8 = arg, bits 7:1 = CRC, bit 0 (end) must be 1
  - CHECK (one clk cycle): load cmd_idx_o/cmd_arg_o; pulse cmd_valid_o.
    - cmd_err_o=1 on any CRC/transmission/end mismatch → IDLE, no response.
    - Otherwise cmd_err_o=0 → WAIT; NCR counter cleared.
  - WAIT: resp_ready_o=1 until accepted; NCR counter increments on each rise and saturates at NCR.
    - On accept, latch all resp_* inputs. Mode 00 → IDLE immediately.
    - Transmission starts at the first fall with counter==NCR and the response latched → SEND.
    - Card logic may delay acceptance arbitrarily; the response then starts at the first fall after acceptance.
  - SEND: sd_cmd_oe=1; one bit per fall, MSB first; total 48 bits (short) or 136 bits (long).
    - short: 0, 0, resp_idx, resp_arg, CRC7 (or 7'h7F in mode 10), 1
    - long: 0, 0, 6'h3F, resp_long, CRC7 over resp_long only, 1
    - The end bit is held one SD period. At the following fall: sd_cmd_oe=0, sd_cmd_o=1 → IDLE.
- Start bits seen on CMD during WAIT or SEND are ignored.
- busy_o=1 in RECV, CHECK, WAIT and SEND.
- rst_i in any state: all outputs take reset values on the next clk_i edge; a partial frame is discarded.
- A stalled SD clock freezes all counters; no timeout is implemented.

Test Plan:
- Host sends CMD0, arg 0, frame 40 00000000 95 → cmd_valid_o pulse with idx=0, arg=0, err=0; mode 00 supplied → sd_cmd_oe stays 0; back to IDLE.
- CMD8, frame 48 000001AA 87; respond mode 01 with idx 8, arg 0x000001AA → line carries 08 000001AA 13. Start bit appears exactly NCR=2 SD periods after the command end bit; oe drops one period after the end bit.
- CMD8 frame with CRC byte 0x86 → cmd_valid_o with cmd_err_o=1; resp_ready_o never asserts; no drive.
- Frame with end bit 0, and separately a frame with transmission bit 0 → cmd_err_o=1 in each case.
- Mode 11 with resp_long_i all ones → 136 bits sent: 0, 0, 6'h3F, 120 ones, computed CRC7, 1. Mode 10 → CRC field is 7'h7F.
- resp_valid_i delayed 10 SD periods → start bit on the first fall after acceptance. rst_i asserted mid-SEND → sd_cmd_oe=0 next clk_i cycle; the next CMD0 frame is received correctly.
